player_jump_ctrl: RTL and testbench
===================================

# player_jump_ctrl

Player physics and landing detector for the platform-jump game. Once per frame it scans the 15 platform positions, applies gravity and horizontal input to the player, and detects landings. It then drives `bump`, `movement` and `hold` back to the platform generator, which uses them to scroll the field and count score. The block sits between the button debouncers, the platform generator's block-position mux and the VGA pixel generator.

## Interface
Parameters:
- `PLAYER_W`, default 16: player sprite width, in px.
- `PLAYER_H`, default 16: player sprite height, in px.
- `BLOCK_W`, default 32: platform width, in px.
- `GRAVITY`, default 1: downward velocity added per frame.
- `JUMP_V`, default 12: upward speed loaded on a landing.
- `MAX_FALL`, default 15: cap on downward velocity.
- `H_SPEED`, default 4: horizontal px moved per frame.
- `SCROLL_LINE`, default 400: landing rows above this line request a scroll.
- `TOP_LINE`, default 64: player rows above this line assert `hold`.
- `LEFT_BOUND` / `RIGHT_BOUND`, default 200 / 440: playfield x limits.

Ports:
- `clk` in 1: the single system clock.
- `rst` in 1: reset. Synchronous, active-low. Sampled on the `clk` edge.
- `state` in 3: game state. WAIT=0, INFORMATION=1, GAME=2, WIN=3, LOSE=4.
- `frame_tick` in 1: one-`clk` pulse per frame (rising edge of clk_22).
- `move_left`, `move_right` in 1 each: debounced button levels.
- `blk_sel` out 4: index of the platform being scanned. Range 1..15; 0 means idle.
- `blk_x`, `blk_y` in 10 each: position of platform `blk_sel`. Combinational from the parent mux and valid in the same cycle.
- `player_x`, `player_y` out 10 each: top-left corner of the player sprite.
- `bump` out 3: landing code. 0 = none; 1 = landed on a fixed block.
- `movement` out 10: scroll distance requested on a landing.
- `hold` out 1: forces a continuous scroll.
- `fall_out` out 1: player has left the bottom of the screen (sticky).

## Operation
- **FSM states:** IDLE, WAIT_TICK, SCAN, UPDATE.
- **IDLE:**
  - Entered whenever `state != GAME`, including mid-scan. Leaving GAME aborts any scan in progress.
  - Every output and the internal velocity `vy` (signed 8-bit) take their reset values:
    - `player_x`=312, `player_y`=440, `vy`=0.
    - `bump`=0, `movement`=0, `hold`=0, `fall_out`=0, `blk_sel`=0.
- **IDLE → WAIT_TICK:** when `state == GAME`.
- **WAIT_TICK → SCAN:** on `frame_tick`. Transition is suppressed while `fall_out`=1, so physics freezes after a fall-out.
- **SCAN:**
  - `blk_sel` steps 1..15, one per `clk` cycle.
  - A platform is a hit when `vy > 0` and all of these hold:
    - feet = `player_y + PLAYER_H`, with feet ≤ `blk_y` and feet + `vy` ≥ `blk_y`;
    - `player_x + PLAYER_W > blk_x`;
    - `player_x < blk_x + BLOCK_W`.
  - The first hit in index order is latched as `hit_y`. Later hits in the same scan are ignored.
- **UPDATE (1 cycle), then back to WAIT_TICK:**
  - **On a hit:**
    - `player_y` = `hit_y - PLAYER_H`;
    - `vy` = `-JUMP_V`;
    - `bump` = 1;
    - `movement` = `SCROLL_LINE - hit_y` if `hit_y < SCROLL_LINE`, else 0.
  - **No hit:**
    - `vy` = min(`vy + GRAVITY`, `MAX_FALL`);
    - `player_y` += `vy` (old `vy`), computed 11-bit signed and clamped at 0;
    - `bump` = 0, `movement` = 0.
  - **Horizontal:**
    - `move_left` subtracts `H_SPEED`; `move_right` adds `H_SPEED`.
    - Both buttons pressed, or neither: no move.
    - Result is clamped to [`LEFT_BOUND`, `RIGHT_BOUND - PLAYER_W`].
  - `hold` = (new `player_y` < `TOP_LINE`).
  - `fall_out` sets when new `player_y + PLAYER_H` > 480.

## Timing
- All outputs are registered.
- `bump` and `movement` update once per frame, in UPDATE. They hold their value until the next UPDATE, so the platform generator sees them for a full clk_22 period.
- Latency: outputs change 17 `clk` cycles after `frame_tick` (1 cycle entering SCAN, 15 scan cycles, 1 UPDATE cycle).
- `frame_tick` arriving in SCAN or UPDATE is dropped; no queuing.
- `rst` low overrides everything. The next cycle is IDLE with all reset values.

## Configuration
- `PLAYER_WRAP_X_EN`:
  - **Defined:** moving past one x bound places the player at the opposite bound, i.e. `LEFT_BOUND` ↔ `RIGHT_BOUND - PLAYER_W`.
  - **Undefined:** the player is clamped at the bounds as described in Operation.

## Test plan
- Reset low 2 cycles, `state`=GAME → `player_x`=312, `player_y`=440, `bump`=0, `fall_out`=0. FSM reaches WAIT_TICK.
- Landing: `player_y`=200, `vy`=5, platform 7 at (300,220), `player_x`=310, one tick → `blk_sel` walks 1..15, then `player_y`=204, `bump`=1, `movement`=180, `vy`=-12.
- Two overlapping hits at indices 3 and 9 → only platform 3's `blk_y` is used. Hold `move_right` at x=420 → `player_x`=424, then stays at 424.
- No platforms under the player, repeated ticks → `vy` saturates at 15; `fall_out`=1 once `player_y`>464. Further ticks leave every output unchanged.
- `state` changed to LOSE at scan cycle 6 → next cycle `blk_sel`=0 and all outputs at reset values. `frame_tick` pulsed during SCAN is ignored.
- With `PLAYER_WRAP_X_EN`, `move_left` at x=202 → `player_x`=424.

Source files
------------

// File: rtl/player_jump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : player_jump_ctrl_if
// Brief   : Game-state, button, platform-scan and player-output bundle.
// Revision: 1.0
// ============================================================================
interface player_jump_ctrl_if;
    logic [2:0] state;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic [3:0] blk_sel;
    logic [9:0] blk_x;
    logic [9:0] blk_y;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [2:0] bump;
    logic [9:0] movement;
    logic       hold;
    logic       fall_out;

    modport master (
        input  state, frame_tick, move_left, move_right, blk_x, blk_y,
        output blk_sel, player_x, player_y, bump, movement, hold, fall_out
    );

    modport slave (
        output state, frame_tick, move_left, move_right, blk_x, blk_y,
        input  blk_sel, player_x, player_y, bump, movement, hold, fall_out
    );
endinterface
`default_nettype wire

// File: rtl/player_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : player_jump_ctrl
// Brief   : Per-frame platform scan, player physics and landing detection.
//           Optional macro PLAYER_WRAP_X_EN wraps x at the playfield bounds.
// Revision: 1.0
// ============================================================================
module player_jump_ctrl #(
    parameter int PLAYER_W    = 16,
    parameter int PLAYER_H    = 16,
    parameter int BLOCK_W     = 32,
    parameter int GRAVITY     = 1,
    parameter int JUMP_V      = 12,
    parameter int MAX_FALL    = 15,
    parameter int H_SPEED     = 4,
    parameter int SCROLL_LINE = 400,
    parameter int TOP_LINE    = 64,
    parameter int LEFT_BOUND  = 200,
    parameter int RIGHT_BOUND = 440
) (
    input  wire logic          clk,
    input  wire logic          rst,
    player_jump_ctrl_if.master bus
);
    localparam logic [2:0]        C_GAME     = 3'd2;
    localparam logic [9:0]        C_X_RESET  = 10'd312;
    localparam logic [9:0]        C_Y_RESET  = 10'd440;
    localparam logic [9:0]        C_X_MIN    = 10'(LEFT_BOUND);
    localparam logic [9:0]        C_X_MAX    = 10'(RIGHT_BOUND - PLAYER_W);
    localparam logic signed [8:0] C_MAX_FALL = 9'(MAX_FALL);
    localparam logic signed [7:0] C_JUMP_VY  = 8'(-JUMP_V);
`ifdef PLAYER_WRAP_X_EN
    localparam logic [9:0]        C_X_UNDER  = C_X_MAX;
    localparam logic [9:0]        C_X_OVER   = C_X_MIN;
`else
    localparam logic [9:0]        C_X_UNDER  = C_X_MIN;
    localparam logic [9:0]        C_X_OVER   = C_X_MAX;
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_SCAN      = 2'd2,
        S_UPDATE    = 2'd3
    } fsm_t;

    fsm_t              state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic signed [7:0] vy_q, vy_d;
    logic [2:0]        bump_q, bump_d;
    logic [9:0]        mov_q, mov_d;
    logic              hold_q, hold_d, fall_q, fall_d;
    logic              hit_q, hit_d;
    logic [9:0]        hity_q, hity_d;

    logic [11:0]        w_feet, w_reach, w_blk_y, w_px_end, w_bx_end;
    logic               w_hit;
    logic signed [8:0]  w_vy_inc;
    logic signed [7:0]  w_vy_fall;
    logic signed [11:0] w_y_fall;
    logic [9:0]         w_y_nohit, w_y_new, w_x_new, w_x_minus;
    logic [10:0]        w_x_plus;
    logic               w_left, w_right, w_fall_new;

    // vy is known positive whenever w_reach matters, so zero-extension is safe
    assign w_feet   = {2'b00, y_q} + 12'(PLAYER_H);
    assign w_reach  = w_feet + {4'b0000, vy_q};
    assign w_blk_y  = {2'b00, bus.blk_y};
    assign w_px_end = {2'b00, x_q} + 12'(PLAYER_W);
    assign w_bx_end = {2'b00, bus.blk_x} + 12'(BLOCK_W);
    assign w_hit    = (vy_q > 8'sd0) && (w_feet <= w_blk_y) && (w_reach >= w_blk_y)
                   && (w_px_end > {2'b00, bus.blk_x}) && ({2'b00, x_q} < w_bx_end);

    assign w_vy_inc  = $signed({vy_q[7], vy_q}) + $signed(9'(GRAVITY));
    assign w_vy_fall = (w_vy_inc > C_MAX_FALL) ? C_MAX_FALL[7:0] : w_vy_inc[7:0];
    assign w_y_fall  = $signed({2'b00, y_q}) + $signed({{4{vy_q[7]}}, vy_q});
    assign w_y_nohit = w_y_fall[11] ? 10'd0 : (w_y_fall[10] ? 10'h3ff : w_y_fall[9:0]);
    assign w_y_new   = hit_q ? (hity_q - 10'(PLAYER_H)) : w_y_nohit;
    assign w_fall_new = ({1'b0, w_y_new} + 11'(PLAYER_H)) > 11'd480;

    assign w_left    = bus.move_left & ~bus.move_right;
    assign w_right   = bus.move_right & ~bus.move_left;
    assign w_x_minus = x_q - 10'(H_SPEED);
    assign w_x_plus  = {1'b0, x_q} + 11'(H_SPEED);

    always_comb begin
        w_x_new = x_q;
        if (w_left) begin
            w_x_new = (x_q < C_X_MIN + 10'(H_SPEED)) ? C_X_UNDER : w_x_minus;
        end else if (w_right) begin
            w_x_new = (w_x_plus > {1'b0, C_X_MAX}) ? C_X_OVER : w_x_plus[9:0];
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        bump_d  = bump_q;
        mov_d   = mov_q;
        hold_d  = hold_q;
        fall_d  = fall_q;
        hit_d   = hit_q;
        hity_d  = hity_q;
        case (state_q)
            S_IDLE: state_d = S_WAIT_TICK;
            S_WAIT_TICK: begin
                // physics freezes for good once the player has dropped off screen
                if (bus.frame_tick && !fall_q) begin
                    state_d = S_SCAN;
                    sel_d   = 4'd1;
                    hit_d   = 1'b0;
                    hity_d  = 10'd0;
                end
            end
            S_SCAN: begin
                if (!hit_q && w_hit) begin
                    hit_d  = 1'b1;
                    hity_d = bus.blk_y;
                end
                if (sel_q == 4'd15) begin
                    sel_d   = 4'd0;
                    state_d = S_UPDATE;
                end else begin
                    sel_d = sel_q + 4'd1;
                end
            end
            S_UPDATE: begin
                state_d = S_WAIT_TICK;
                x_d     = w_x_new;
                y_d     = w_y_new;
                if (hit_q) begin
                    vy_d   = C_JUMP_VY;
                    bump_d = 3'd1;
                    mov_d  = (hity_q < 10'(SCROLL_LINE)) ? (10'(SCROLL_LINE) - hity_q) : 10'd0;
                end else begin
                    vy_d   = w_vy_fall;
                    bump_d = 3'd0;
                    mov_d  = 10'd0;
                end
                hold_d = (w_y_new < 10'(TOP_LINE));
                fall_d = fall_q | w_fall_new;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.state != C_GAME) begin
            state_d = S_IDLE;
            sel_d   = 4'd0;
            x_d     = C_X_RESET;
            y_d     = C_Y_RESET;
            vy_d    = 8'sd0;
            bump_d  = 3'd0;
            mov_d   = 10'd0;
            hold_d  = 1'b0;
            fall_d  = 1'b0;
            hit_d   = 1'b0;
            hity_d  = 10'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= 4'd0;
            x_q     <= C_X_RESET;
            y_q     <= C_Y_RESET;
            vy_q    <= 8'sd0;
            bump_q  <= 3'd0;
            mov_q   <= 10'd0;
            hold_q  <= 1'b0;
            fall_q  <= 1'b0;
            hit_q   <= 1'b0;
            hity_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            bump_q  <= bump_d;
            mov_q   <= mov_d;
            hold_q  <= hold_d;
            fall_q  <= fall_d;
            hit_q   <= hit_d;
            hity_q  <= hity_d;
        end
    end

    assign bus.blk_sel  = sel_q;
    assign bus.player_x = x_q;
    assign bus.player_y = y_q;
    assign bus.bump     = bump_q;
    assign bus.movement = mov_q;
    assign bus.hold     = hold_q;
    assign bus.fall_out = fall_q;
endmodule
`default_nettype wire

// File: tb/tb_player_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_jump_ctrl
// Brief   : Directed bench with a physics model and output scoreboard.
// Revision: 1.0
// ============================================================================
module tb_player_jump_ctrl;
    localparam logic [2:0] ST_GAME = 3'd2;
    localparam logic [2:0] ST_LOSE = 3'd4;

    typedef struct {
        int x; int y; int bump; int mov; int hold; int fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    player_jump_ctrl_if bus();
    player_jump_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    logic [9:0] tx [16];
    logic [9:0] ty [16];
    always_comb begin
        bus.blk_x = tx[bus.blk_sel];
        bus.blk_y = ty[bus.blk_sel];
    end

    exp_t sb[$];
    int   sel_sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_x, m_y, m_vy, m_bump, m_mov;
    bit   m_hold, m_fall;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 312; m_y = 440; m_vy = 0; m_bump = 0; m_mov = 0; m_hold = 0; m_fall = 0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.x = m_x; e.y = m_y; e.bump = m_bump; e.mov = m_mov; e.hold = int'(m_hold); e.fall = int'(m_fall);
        sb.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_x"},    int'(bus.player_x), e.x);
        chk({tag, "_y"},    int'(bus.player_y), e.y);
        chk({tag, "_bump"}, int'(bus.bump),     e.bump);
        chk({tag, "_mov"},  int'(bus.movement), e.mov);
        chk({tag, "_hold"}, int'(bus.hold),     e.hold);
        chk({tag, "_fall"}, int'(bus.fall_out), e.fall);
    endtask

    task automatic model_frame(input bit left, input bit right);
        bit hit;
        int hy, feet, bx, by, nx;
        if (!m_fall) begin
            hit = 0; hy = 0; feet = m_y + 16;
            for (int i = 1; i < 16; i++) begin
                bx = int'(tx[i]); by = int'(ty[i]);
                if (!hit && m_vy > 0 && feet <= by && feet + m_vy >= by && m_x + 16 > bx && m_x < bx + 32) begin
                    hit = 1; hy = by;
                end
            end
            if (hit) begin
                m_y = hy - 16; m_vy = -12; m_bump = 1;
                m_mov = (hy < 400) ? 400 - hy : 0;
            end else begin
                m_y = m_y + m_vy;
                if (m_y < 0) m_y = 0;
                m_vy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
                m_bump = 0; m_mov = 0;
            end
            nx = m_x;
            if (left && !right) nx = m_x - 4;
            else if (right && !left) nx = m_x + 4;
`ifdef PLAYER_WRAP_X_EN
            if (nx < 200) nx = 424; else if (nx > 424) nx = 200;
`else
            if (nx < 200) nx = 200; else if (nx > 424) nx = 424;
`endif
            m_x = nx;
            m_hold = (m_y < 64);
            if (m_y + 16 > 480) m_fall = 1;
        end
        push_expect();
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) begin
            tx[i] = 10'd0; ty[i] = 10'd0;
        end
    endtask

    task automatic do_frame(input bit left, input bit right, input int extra_at, input int abort_at);
        bit frozen;
        frozen = m_fall;
        bus.move_left = left; bus.move_right = right;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        for (int k = 1; k <= 16; k++) sel_sb.push_back((frozen || k == 16) ? 0 : k);
        if (abort_at == 0) model_frame(left, right);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("blk_sel", int'(bus.blk_sel), sel_sb.pop_front());
            bus.frame_tick = (k == extra_at);
            if (k == abort_at) begin
                bus.state = ST_LOSE;
                break;
            end
            @(negedge clk);
        end
        bus.frame_tick = 1'b0;
        sel_sb.delete();
        if (abort_at == 0) begin
            check_outputs("frame");
        end else begin
            @(negedge clk);
            model_reset();
            push_expect();
            chk("abort_sel", int'(bus.blk_sel), 0);
            check_outputs("abort");
        end
    endtask

    function automatic bit btn_left(input int f);
        return (f >= 38);
    endfunction

    function automatic bit btn_right(input int f);
        return (f >= 8 && f < 42);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, j, feet;
        clear_table();
        rst = 1'b0;
        bus.state = ST_GAME;
        bus.frame_tick = 1'b0;
        bus.move_left = 1'b0;
        bus.move_right = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        push_expect();
        chk("reset_sel", int'(bus.blk_sel), 0);
        check_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Climb: land at the apex of every jump, alternating exact-feet and overlapping platforms
        f = 0; j = 0;
        while (j < 6 && f < 200) begin
            clear_table();
            feet = m_y + 16;
            if (m_vy == ((j % 2 == 1) ? 2 : 1)) begin
                tx[1] = 10'(m_x + 16); ty[1] = 10'(feet);
                tx[2] = 10'(m_x - 32); ty[2] = 10'(feet);
                tx[4] = 10'(m_x);      ty[4] = 10'(feet + m_vy + 1);
                if (j % 2 == 1) begin
                    tx[3] = 10'(m_x - 31); ty[3] = 10'(feet + 2);
                    tx[9] = 10'(m_x + 15); ty[9] = 10'(feet + 1);
                end else begin
                    tx[7] = 10'(m_x); ty[7] = 10'(feet);
                end
                j++;
            end
            do_frame(btn_left(f), btn_right(f), 0, 0);
            f++;
        end

        clear_table();
        while (!m_fall && f < 300) begin
            do_frame(btn_left(f), btn_right(f), 0, 0);
            f++;
        end
        chk("fell_out", int'(bus.fall_out), 1);
        repeat (3) do_frame(1'b0, 1'b1, 0, 0);

        @(negedge clk);
        bus.state = ST_LOSE;
        @(negedge clk);
        model_reset();
        push_expect();
        check_outputs("lose");
        bus.state = ST_GAME;
        @(negedge clk);

        do_frame(1'b0, 1'b0, 4, 0);
        repeat (20) @(negedge clk);
        push_expect();
        chk("idle_sel", int'(bus.blk_sel), 0);
        check_outputs("dropped_tick");

        do_frame(1'b0, 1'b1, 0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
